// File: rtl/io_port_bridge_pkg.sv
// Shared constants, types and the access decoder for the I/O port bridge.
// Optional sent-byte statistics are enabled with IO_PORT_STATS_EN.
`ifndef IO_BYTE_LANE
`define IO_BYTE_LANE(w, i) w[{i, 3'b000} +: 8]
`endif

package io_port_bridge_pkg;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_UART = 18'd0;
    localparam logic [17:0] IO_CNT  = 18'd4;
    localparam logic [17:0] IO_STAT = 18'd8;
    localparam logic [17:0] IO_ERR  = 18'd12;
    localparam logic [1:0]  IO_SEL_BITS = 2'b11;

    localparam logic [17:0] A_UART = IO_BASE + IO_UART;
    localparam logic [17:0] A_CNT  = IO_BASE + IO_CNT;
    localparam logic [17:0] A_STAT = IO_BASE + IO_STAT;
    localparam logic [17:0] A_ERR  = IO_BASE + IO_ERR;

    typedef enum logic [3:0] {
        ACC_NONE,
        ACC_PUSH,
        ACC_STOP,
        ACC_RX,
        ACC_CNT0,
        ACC_CNTN,
        ACC_STAT0,
        ACC_STATN,
        ACC_ERR,
        ACC_RD0
    } io_acc_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOP,
        ST_END
    } io_state_e;

    // Byte 0 of a multi-byte register re-latches; bytes 1..3 read the latch.
    function automatic io_acc_e io_decode(input logic wr,
                                          input logic [17:0] a);
        io_acc_e acc;
        acc = ACC_NONE;
        unique case (1'b1)
            wr && a == A_UART: acc = ACC_PUSH;
            wr && a == A_CNT:  acc = ACC_STOP;
            !wr && a == A_UART: acc = ACC_RX;
            !wr && a == A_CNT:  acc = ACC_CNT0;
            !wr && a[17:2] == A_CNT[17:2] && a[1:0] != 2'd0:
                acc = ACC_CNTN;
            !wr && a == A_STAT: acc = ACC_STAT0;
            !wr && a[17:2] == A_STAT[17:2] && a[1:0] != 2'd0:
                acc = ACC_STATN;
            !wr && a == A_ERR:  acc = ACC_ERR;
            default: acc = wr ? ACC_NONE : ACC_RD0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/io_port_bridge_if.sv
// CPU-side byte bus between the core and the I/O port bridge.
// No configuration macros affect this file.
interface io_port_bridge_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  io_dout;
    logic        io_buffer_full;

    modport master (
        output mem_a, mem_dout, mem_wr,
        input  io_dout, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr,
        output io_dout, io_buffer_full
    );
endinterface

// File: rtl/io_byte_fifo.sv
// Byte FIFO for UART output; power-of-two depth, drops pushes when full.
// No configuration macros affect this file.
module io_byte_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nx,
    output logic          empty,
    output logic          full
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        unique case ({do_push, do_pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nx;
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// Memory-mapped I/O at 0x30000: UART tx FIFO, rx reads, cycle counter, stop.
// Define IO_PORT_STATS_EN to add the sent-byte counter and overflow flag reads.
module io_port_bridge
    import io_port_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    io_port_bridge_if.slave  bus,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_full,
    input  logic [7:0]       rx_data,
    input  logic             rx_empty,
    output logic             rx_pop,
    output logic             prog_end
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] FULL_MARK = (CW+1)'(FIFO_DEPTH - 1);

    io_acc_e          acc;
    io_state_e        state;
    logic             io_sel;
    logic [1:0]       lane;
    logic [7:0]       rd_data;
    logic             push_req;
    logic             drain;
    logic             stop_emit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_latch;
    logic             overflow_err;
    logic [7:0]       f_head;
    logic [CW:0]      f_count;
    logic [CW:0]      f_count_nx;
    logic             f_empty;
    logic             f_full;
    logic             unused_bits;

    assign io_sel = rdy_in && bus.mem_a[17:16] == IO_SEL_BITS;
    assign acc    = io_sel ? io_decode(bus.mem_wr, bus.mem_a[17:0])
                           : ACC_NONE;
    assign lane   = bus.mem_a[1:0];

    // Output bytes are only accepted while no stop has been requested.
    assign push_req = acc == ACC_PUSH && bus.mem_dout != 8'h00
                      && state == ST_RUN;
    assign drain     = rdy_in && !tx_full && !f_empty;
    assign stop_emit = rdy_in && !tx_full && f_empty && state == ST_STOP;
    assign tx_valid  = drain || stop_emit;
    assign tx_data   = drain ? f_head : 8'h00;
    assign rx_pop    = acc == ACC_RX && !rx_empty;

    io_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (push_req),
        .pop      (drain),
        .din      (bus.mem_dout),
        .head     (f_head),
        .count    (f_count),
        .count_nx (f_count_nx),
        .empty    (f_empty),
        .full     (f_full)
    );

    // Free-running: ignores rdy_in so software can time stalls too.
    always_ff @(posedge clk_in) begin
        if (rst_in) cnt <= '0;
        else        cnt <= cnt + 1'b1;
    end

`ifdef IO_PORT_STATS_EN
    logic [31:0] sent_cnt;
    logic [31:0] stat_latch;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sent_cnt   <= '0;
            stat_latch <= '0;
        end else if (rdy_in) begin
            if (tx_valid)          sent_cnt   <= sent_cnt + 1'b1;
            if (acc == ACC_STAT0)  stat_latch <= sent_cnt;
        end
    end

    assign unused_bits = ^{bus.mem_a[31:18], f_count};
`else
    assign unused_bits = ^{bus.mem_a[31:18], f_count, overflow_err};
`endif

    always_comb begin
        rd_data = 8'h00;
        case (acc)
            ACC_RX:    rd_data = rx_empty ? 8'h00 : rx_data;
            ACC_CNT0:  rd_data = cnt[7:0];
            ACC_CNTN:  rd_data = `IO_BYTE_LANE(cnt_latch, lane);
`ifdef IO_PORT_STATS_EN
            ACC_STAT0: rd_data = sent_cnt[7:0];
            ACC_STATN: rd_data = `IO_BYTE_LANE(stat_latch, lane);
            ACC_ERR:   rd_data = {7'b0, overflow_err};
`endif
            default:   rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= ST_RUN;
            prog_end           <= 1'b0;
            bus.io_dout        <= 8'h00;
            bus.io_buffer_full <= 1'b0;
            cnt_latch          <= '0;
            overflow_err       <= 1'b0;
        end else if (rdy_in) begin
            bus.io_buffer_full <= f_count_nx >= FULL_MARK;
            if (push_req && f_full) overflow_err <= 1'b1;
            if (acc == ACC_CNT0)    cnt_latch    <= cnt;
            if (io_sel && !bus.mem_wr) bus.io_dout <= rd_data;
            unique case (state)
                ST_RUN: begin
                    if (acc == ACC_STOP) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (stop_emit) begin
                        state    <= ST_END;
                        prog_end <= 1'b1;
                    end
                end
                ST_END:  state <= ST_END;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed bench for io_port_bridge: counter, rx, tx drain, overflow, stop.
// Built with IO_PORT_STATS_EN undefined.
module tb_io_port_bridge;

    localparam logic [31:0] UART = 32'h0003_0000;
    localparam logic [31:0] CNT  = 32'h0003_0004;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       rdy_in = 1'b1;
    logic       tx_full = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       rx_pop;
    logic       prog_end;
    int         n_checks = 0;
    int         n_err = 0;

    io_port_bridge_if bus ();

    io_port_bridge #(
        .FIFO_DEPTH(8),
        .CNT_W(32)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .bus      (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_full  (tx_full),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_pop   (rx_pop),
        .prog_end (prog_end)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [31:0] a, input logic wr,
                       input logic [7:0] d);
        @(negedge clk);
        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.mem_dout = d;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.mem_a    = 32'h0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        chk("rst_io_dout", 32'(bus.io_dout), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_rx_pop", 32'(rx_pop), 32'h0);
        chk("rst_prog_end", 32'(prog_end), 32'h0);
        chk("rst_buf_full", 32'(bus.io_buffer_full), 32'h0);

        // counter reads 1000 when the 0x30004 read is sampled
        repeat (999) @(negedge clk);
        cyc(CNT, 1'b0, 8'h00);
        cyc(CNT + 1, 1'b0, 8'h00);
        chk("cnt_b0", 32'(bus.io_dout), 32'hE8);
        cyc(CNT + 2, 1'b0, 8'h00);
        chk("cnt_b1", 32'(bus.io_dout), 32'h03);
        cyc(CNT + 3, 1'b0, 8'h00);
        chk("cnt_b2", 32'(bus.io_dout), 32'h00);
        cyc(32'h0, 1'b0, 8'h00);
        chk("cnt_b3", 32'(bus.io_dout), 32'h00);

        // rdy low: no push, no rx_pop, counter keeps running
        cyc(UART, 1'b1, 8'h55);
        rdy_in = 1'b0;
        rx_empty = 1'b0;
        rx_data = 8'h77;
        #1;
        cyc(UART, 1'b0, 8'h00);
        chk("rdy_rx_pop", 32'(rx_pop), 32'h0);
        repeat (18) cyc(32'h0, 1'b0, 8'h00);
        cyc(CNT, 1'b0, 8'h00);
        rdy_in = 1'b1;
        rx_empty = 1'b1;
        #1;
        chk("rdy_no_push", 32'(tx_valid), 32'h0);
        cyc(CNT + 1, 1'b0, 8'h00);
        chk("rdy_cnt_b0", 32'(bus.io_dout), 32'h01);
        cyc(32'h0, 1'b0, 8'h00);
        chk("rdy_cnt_b1", 32'(bus.io_dout), 32'h04);

        // three bytes stream out back to back
        cyc(UART, 1'b1, 8'h41);
        chk("wr_empty", 32'(tx_valid), 32'h0);
        cyc(UART, 1'b1, 8'h42);
        chk("tx_41", 32'({tx_valid, tx_data}), 32'h141);
        cyc(UART, 1'b1, 8'h43);
        chk("tx_42", 32'({tx_valid, tx_data}), 32'h142);
        cyc(32'h0, 1'b0, 8'h00);
        chk("tx_43", 32'({tx_valid, tx_data}), 32'h143);
        cyc(32'h0, 1'b0, 8'h00);
        chk("tx_idle", 32'(tx_valid), 32'h0);

        // zero byte is not queued
        cyc(UART, 1'b1, 8'h00);
        cyc(32'h0, 1'b0, 8'h00);
        chk("zero_wr", 32'(tx_valid), 32'h0);

        // rx read with and without data
        cyc(UART, 1'b0, 8'h00);
        rx_data = 8'h5A;
        rx_empty = 1'b0;
        #1;
        chk("rx_pop_hit", 32'(rx_pop), 32'h1);
        cyc(32'h0, 1'b0, 8'h00);
        rx_empty = 1'b1;
        #1;
        chk("rx_data", 32'(bus.io_dout), 32'h5A);
        chk("rx_pop_idle", 32'(rx_pop), 32'h0);
        cyc(UART, 1'b0, 8'h00);
        chk("rx_pop_empty", 32'(rx_pop), 32'h0);
        cyc(32'h0, 1'b0, 8'h00);
        chk("rx_empty_rd", 32'(bus.io_dout), 32'h0);

        // fill under back-pressure, then overflow
        cyc(32'h0, 1'b0, 8'h00);
        tx_full = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            cyc(UART, 1'b1, 8'(8'h10 + i));
            if (i == 6) chk("full_at6", 32'(bus.io_buffer_full), 32'h0);
        end
        cyc(32'h0, 1'b0, 8'h00);
        chk("full_at7", 32'(bus.io_buffer_full), 32'h1);
        chk("bp_no_tx", 32'(tx_valid), 32'h0);
        cyc(UART, 1'b1, 8'h17);
        cyc(UART, 1'b1, 8'h18);
        cyc(32'h0, 1'b0, 8'h00);
        chk("overflow", 32'(dut.overflow_err), 32'h1);
        cyc(32'h0, 1'b0, 8'h00);
        tx_full = 1'b0;
        #1;
        chk("drain_0", 32'({tx_valid, tx_data}), 32'h110);
        for (int i = 1; i < 8; i++) begin
            cyc(32'h0, 1'b0, 8'h00);
            chk($sformatf("drain_%0d", i), 32'({tx_valid, tx_data}),
                32'h110 + 32'(i));
        end
        cyc(32'h0, 1'b0, 8'h00);
        chk("drain_end", 32'(tx_valid), 32'h0);
        chk("full_clr", 32'(bus.io_buffer_full), 32'h0);

        // "hi" then stop
        cyc(UART, 1'b1, 8'h68);
        cyc(UART, 1'b1, 8'h69);
        chk("stop_h", 32'({tx_valid, tx_data}), 32'h168);
        cyc(CNT, 1'b1, 8'h00);
        chk("stop_i", 32'({tx_valid, tx_data}), 32'h169);
        cyc(32'h0, 1'b0, 8'h00);
        chk("stop_nul", 32'({tx_valid, tx_data}), 32'h100);
        chk("stop_pe0", 32'(prog_end), 32'h0);
        cyc(32'h0, 1'b0, 8'h00);
        chk("stop_pe1", 32'(prog_end), 32'h1);
        chk("stop_quiet", 32'(tx_valid), 32'h0);
        cyc(UART, 1'b1, 8'h41);
        cyc(32'h0, 1'b0, 8'h00);
        chk("post_stop_wr", 32'(tx_valid), 32'h0);
        chk("pe_sticky", 32'(prog_end), 32'h1);

        // reset discards queued bytes and clears prog_end
        cyc(32'h0, 1'b0, 8'h00);
        rst_in = 1'b1;
        #1;
        cyc(32'h0, 1'b0, 8'h00);
        rst_in = 1'b0;
        #1;
        chk("rst_pe", 32'(prog_end), 32'h0);
        cyc(UART, 1'b1, 8'h33);
        tx_full = 1'b1;
        #1;
        cyc(32'h0, 1'b0, 8'h00);
        rst_in = 1'b1;
        #1;
        cyc(32'h0, 1'b0, 8'h00);
        rst_in = 1'b0;
        tx_full = 1'b0;
        #1;
        chk("rst_drop", 32'(tx_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Sits directly downstream of the CPU top's byte memory bus, in parallel with the RAM, and serves every access with mem_a[17:16]==2'b11.
- Buffers UART output bytes in a FIFO and drains them to the UART transmitter under the transmitter's full flag.
- Serves UART input reads and the free-running cycle counter.
- Produces io_buffer_full back to the CPU, plus program-end signalling.

Parameters:
- FIFO_DEPTH, 8, output byte FIFO entries; power of two, at least 4.
- CNT_W, 32, cycle counter width; fixed at 32.

Ports:
- clk_in  input  1  system clock (sole clock).
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global ready; low freezes all state except the cycle counter.
- mem_a  input  32  CPU address bus.
- mem_dout  input  8  CPU write data.
- mem_wr  input  1  1 = write, 0 = read.
- io_dout  output  8  read data returned to the CPU.
- io_buffer_full  output  1  to CPU; CPU must not issue an I/O write while high.
- tx_data  output  8  byte to the UART transmitter.
- tx_valid  output  1  tx_data is valid this cycle.
- tx_full  input  1  UART transmitter cannot accept.
- rx_data  input  8  UART received byte.
- rx_empty  input  1  no received byte available.
- rx_pop  output  1  consume rx_data.
- prog_end  output  1  sticky; program stop written and FIFO fully drained.

Behaviour:
- Reset values: io_dout=0, tx_valid=0, tx_data=0, rx_pop=0, prog_end=0, io_buffer_full=0. FIFO empty; counter=0; stop_pending=0.
- I/O select: io_sel = (mem_a[17:16]==2'b11) & rdy_in. No action when io_sel=0.
- Write to 0x30000 with mem_dout != 0: push the byte. mem_dout==0 is ignored.
- Write to 0x30004: set stop_pending. Further output pushes after that are ignored.
- Read from 0x30000: io_dout=rx_data on the next cycle. rx_pop pulses 1 cycle, same cycle as the request, only if rx_empty=0. If rx_empty=1, return 0.
- Read from 0x30004: snapshot the counter into cnt_latch and return byte 0 on the next cycle.
- Reads from 0x30005..0x30007: return cnt_latch bytes 1..3 on the next cycle. These reads do not re-latch, so a 4-byte read sequence is coherent.
- Counter: increments every clk_in cycle after reset, including while rdy_in=0. Wraps at 2^32.
- Read latency: exactly 1 cycle, matching RAM. io_dout holds its value until the next I/O read.
- Drain: when the FIFO is non-empty and tx_full=0, output tx_valid=1 with tx_data=head, and pop in the same cycle. At most 1 byte per cycle.
- Simultaneous push and pop: allowed; count unchanged.
- io_buffer_full is registered: 1 when count >= FIFO_DEPTH-1. This leaves 1 slot of margin for the write already in flight.
- Push when count==FIFO_DEPTH: byte dropped. Set overflow_err (internal, see Optional Feature).
- Stop sequence: when stop_pending=1 and the FIFO is empty and tx_full=0, emit tx_data=0x00 with tx_valid=1 for 1 cycle. Then set prog_end=1 and hold it until reset.
- rdy_in=0: no push, pop, tx_valid or rx_pop. FIFO pointers frozen.
- Reset mid-drain: the FIFO is cleared; bytes not yet sent are lost.

Optional Feature:
- Macro: IO_PORT_STATS_EN.
- With the macro:
  - A 32-bit sent-byte counter increments on each tx_valid.
  - Reads from 0x30008..0x3000B return its bytes (little-endian, latched on the 0x30008 read).
  - Address 0x3000C returns {7'b0, overflow_err}.
- Without the macro: these addresses read 0; no counter logic is instantiated.

Decomposition:
- Shared package/const header holds:
  - IO_BASE = 18'h30000; offsets IO_UART=0, IO_CNT=4, IO_STAT=8, IO_ERR=12.
  - IO_SEL_BITS = 2'b11.
  - Byte-lane select macro.
- One natural sub-module: io_byte_fifo (parameterised depth; push/pop/count/full/empty).

Test Plan:
- Write 0x41, 0x42, 0x43 to 0x30000 with tx_full=0 -> tx_data 0x41, 0x42, 0x43 on 3 consecutive cycles, starting 1 cycle after the first write.
- Hold tx_full=1 and write 7 bytes with FIFO_DEPTH=8 -> io_buffer_full=1 after the 7th; release tx_full -> all 7 bytes drain in order. An 8th and 9th forced write -> 8th stored, 9th dropped, overflow_err=1.
- Write 0x00 to 0x30000 -> no push and no tx_valid.
- Counter at 1000 -> read 0x30004..0x30007 over 4 cycles -> returns 0xE8, 0x03, 0x00, 0x00 even though the counter advanced.
- rx_data=0x5A with rx_empty=0, read 0x30000 -> rx_pop=1 that cycle, io_dout=0x5A next cycle. With rx_empty=1 -> io_dout=0, rx_pop=0.
- Queue "hi" and then write 0x30004 -> tx sequence 0x68, 0x69, 0x00; prog_end=1 the cycle after 0x00. A further write of 0x41 -> ignored.
